// File: rtl/timer_ctrl.sv
// Run controller for an external flex counter: latches a rollover value
// and a repetition count on start, enables the counter until that many
// rollover events have been seen, then pulses done for one cycle.
// Pause holds the counter and abort cancels the run. All status outputs
// are decoded from state or taken straight from registers.
module timer_ctrl #(
    parameter int unsigned NUM_BITS  = 4,
    parameter int unsigned REPS_BITS = 8
) (
    input  logic                 clk,
    input  logic                 nrst,
    input  logic                 start,
    input  logic                 abort,
    input  logic                 pause,
    input  logic [NUM_BITS-1:0]  period,
    input  logic [REPS_BITS-1:0] reps,
    input  logic                 rollover_flag,
    output logic                 clear,
    output logic                 count_enable,
    output logic [NUM_BITS-1:0]  rollover_val,
    output logic                 busy,
    output logic                 done,
    output logic [REPS_BITS-1:0] reps_left
);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        PAUSED,
        DONE
    } state_t;

    state_t state;
    state_t next_state;

    logic start_ok;
    logic last_event;

    assign start_ok   = start && (period != '0) && (reps != '0);
    assign last_event = rollover_flag && (reps_left == REPS_BITS'(1));

    // State register
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state selection; abort overrides everything outside IDLE
    always_comb begin
        next_state = state;
        unique case (state)
            IDLE: begin
                if (start_ok) begin
                    next_state = RUN;
                end
            end
            RUN: begin
                if (abort) begin
                    next_state = IDLE;
                end else if (last_event) begin
                    next_state = DONE;
                end else if (pause) begin
                    next_state = PAUSED;
                end
            end
            PAUSED: begin
                if (abort) begin
                    next_state = IDLE;
                end else if (!pause) begin
                    next_state = RUN;
                end
            end
            DONE: begin
                next_state = IDLE;
            end
            default: begin
                next_state = IDLE;
            end
        endcase
    end

    // Moore output decode from state only
    always_comb begin
        clear        = 1'b0;
        count_enable = 1'b0;
        busy         = 1'b0;
        done         = 1'b0;
        unique case (state)
            IDLE:    clear        = 1'b1;
            RUN: begin
                count_enable = 1'b1;
                busy         = 1'b1;
            end
            PAUSED:  busy         = 1'b1;
            DONE:    done         = 1'b1;
            default: clear        = 1'b1;
        endcase
    end

    // Run parameters: latched on accepted start, repetition count consumed per event
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            rollover_val <= '0;
            reps_left    <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (start_ok) begin
                        rollover_val <= period;
                        reps_left    <= reps;
                    end
                end
                RUN: begin
                    if (abort) begin
                        reps_left <= '0;
                    end else if (rollover_flag && (reps_left != '0)) begin
                        reps_left <= reps_left - REPS_BITS'(1);
                    end
                end
                PAUSED, DONE: begin
                    if (abort) begin
                        reps_left <= '0;
                    end
                end
                default: begin
                    reps_left <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_timer_ctrl.sv
// Directed bench for timer_ctrl with a small flex counter attached: the
// counter counts 0..rollover_val-1 and raises rollover_flag during the
// last count of each period, so one period is exactly rollover_val
// enabled cycles.
module tb_timer_ctrl;

    logic       clk;
    logic       nrst;
    logic       start;
    logic       abort;
    logic       pause;
    logic [3:0] period;
    logic [7:0] reps;
    logic       rollover_flag;
    logic       clear;
    logic       count_enable;
    logic [3:0] rollover_val;
    logic       busy;
    logic       done;
    logic [7:0] reps_left;

    logic [3:0] cnt;
    int         cyc;
    int         ce_cycles;
    int         checks;
    int         errors;

    timer_ctrl #(
        .NUM_BITS (4),
        .REPS_BITS(8)
    ) dut (
        .clk          (clk),
        .nrst         (nrst),
        .start        (start),
        .abort        (abort),
        .pause        (pause),
        .period       (period),
        .reps         (reps),
        .rollover_flag(rollover_flag),
        .clear        (clear),
        .count_enable (count_enable),
        .rollover_val (rollover_val),
        .busy         (busy),
        .done         (done),
        .reps_left    (reps_left)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Flex counter model driven by the controller
    always @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            cnt <= 4'd0;
        end else if (clear) begin
            cnt <= 4'd0;
        end else if (count_enable) begin
            cnt <= (cnt == rollover_val - 4'd1) ? 4'd0 : cnt + 4'd1;
        end
    end

    assign rollover_flag = (rollover_val != 4'd0) && (cnt == rollover_val - 4'd1);

    // Edge and enabled-cycle counters
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (count_enable) begin
            ce_cycles <= ce_cycles + 1;
        end
    end

    initial begin
        cyc       = 0;
        ce_cycles = 0;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int e0;
        int ce0;
        logic done_seen;

        checks = 0;
        errors = 0;
        nrst   = 1'b0;
        start  = 1'b0;
        abort  = 1'b0;
        pause  = 1'b0;
        period = 4'd0;
        reps   = 8'd0;

        // Power-on reset
        #2;
        chk("rst_clear", 32'(clear), 1);
        chk("rst_ce", 32'(count_enable), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_done", 32'(done), 0);
        chk("rst_rv", 32'(rollover_val), 0);
        chk("rst_rl", 32'(reps_left), 0);
        step();
        step();
        nrst = 1'b1;
        step();
        chk("rel_clear", 32'(clear), 1);

        // Basic run P=4 R=3
        period = 4'd4;
        reps   = 8'd3;
        start  = 1'b1;
        step();
        start = 1'b0;
        e0  = cyc;
        ce0 = ce_cycles;
        chk("basic_busy", 32'(busy), 1);
        chk("basic_ce", 32'(count_enable), 1);
        chk("basic_clear", 32'(clear), 0);
        chk("basic_rv", 32'(rollover_val), 4);
        chk("basic_rl3", 32'(reps_left), 3);
        repeat (3) step();
        chk("basic_rl3_hold", 32'(reps_left), 3);
        step();
        chk("basic_rl2", 32'(reps_left), 2);
        repeat (4) step();
        chk("basic_rl1", 32'(reps_left), 1);
        for (int i = 0; i < 40 && done !== 1'b1; i++) step();
        chk("basic_done", 32'(done), 1);
        chk("basic_len", 32'(cyc - e0), 12);
        chk("basic_ce_cycles", 32'(ce_cycles - ce0), 12);
        chk("basic_rl0", 32'(reps_left), 0);
        chk("basic_busy_done", 32'(busy), 0);
        step();
        chk("basic_done_pulse", 32'(done), 0);
        chk("basic_clear_after", 32'(clear), 1);
        chk("basic_cnt0", 32'(cnt), 0);

        // Pause for three cycles mid-period, P=6 R=2
        period = 4'd6;
        reps   = 8'd2;
        start  = 1'b1;
        step();
        start = 1'b0;
        e0  = cyc;
        ce0 = ce_cycles;
        repeat (2) step();
        pause = 1'b1;
        step();
        chk("pause_busy1", 32'(busy), 1);
        chk("pause_ce1", 32'(count_enable), 0);
        step();
        chk("pause_ce2", 32'(count_enable), 0);
        step();
        pause = 1'b0;
        chk("pause_ce3", 32'(count_enable), 0);
        chk("pause_busy3", 32'(busy), 1);
        step();
        chk("pause_resume", 32'(count_enable), 1);
        for (int i = 0; i < 40 && done !== 1'b1; i++) step();
        chk("pause_done", 32'(done), 1);
        chk("pause_len", 32'(cyc - e0), 15);
        chk("pause_ce_cycles", 32'(ce_cycles - ce0), 12);
        step();

        // Abort during the second period, P=9 R=4
        period    = 4'd9;
        reps      = 8'd4;
        start     = 1'b1;
        done_seen = 1'b0;
        step();
        start = 1'b0;
        for (int i = 0; i < 11; i++) begin
            done_seen = done_seen | done;
            step();
        end
        chk("abort_rl3", 32'(reps_left), 3);
        abort = 1'b1;
        step();
        abort = 1'b0;
        chk("abort_busy", 32'(busy), 0);
        chk("abort_clear", 32'(clear), 1);
        chk("abort_rl0", 32'(reps_left), 0);
        chk("abort_done", 32'(done), 0);
        chk("abort_ce", 32'(count_enable), 0);
        for (int i = 0; i < 30; i++) begin
            done_seen = done_seen | done;
            step();
        end
        chk("abort_no_done", 32'(done_seen), 0);

        // Rejected starts leave registers untouched
        period = 4'd5;
        reps   = 8'd0;
        start  = 1'b1;
        step();
        start = 1'b0;
        chk("reps0_busy", 32'(busy), 0);
        chk("reps0_clear", 32'(clear), 1);
        chk("reps0_rv", 32'(rollover_val), 9);
        chk("reps0_rl", 32'(reps_left), 0);
        period = 4'd0;
        reps   = 8'd3;
        start  = 1'b1;
        step();
        start = 1'b0;
        chk("per0_busy", 32'(busy), 0);
        chk("per0_rv", 32'(rollover_val), 9);
        chk("per0_rl", 32'(reps_left), 0);

        // P=1: one event every RUN cycle
        period = 4'd1;
        reps   = 8'd5;
        start  = 1'b1;
        step();
        start = 1'b0;
        e0  = cyc;
        ce0 = ce_cycles;
        chk("p1_rl5", 32'(reps_left), 5);
        step();
        chk("p1_rl4", 32'(reps_left), 4);
        for (int i = 0; i < 40 && done !== 1'b1; i++) step();
        chk("p1_done", 32'(done), 1);
        chk("p1_len", 32'(cyc - e0), 5);
        chk("p1_ce_cycles", 32'(ce_cycles - ce0), 5);
        step();

        // Pause on the final event finishes instead of pausing; start in DONE ignored
        period = 4'd2;
        reps   = 8'd1;
        start  = 1'b1;
        step();
        start = 1'b0;
        step();
        pause = 1'b1;
        step();
        pause = 1'b0;
        chk("coinc_done", 32'(done), 1);
        chk("coinc_busy", 32'(busy), 0);
        period = 4'd3;
        reps   = 8'd2;
        start  = 1'b1;
        step();
        start = 1'b0;
        chk("done_start_busy", 32'(busy), 0);
        chk("done_start_clear", 32'(clear), 1);
        chk("done_start_rv", 32'(rollover_val), 2);

        // Pause on a non-final event: decrement and pause together
        period = 4'd2;
        reps   = 8'd2;
        start  = 1'b1;
        step();
        start = 1'b0;
        step();
        pause = 1'b1;
        step();
        pause = 1'b0;
        chk("evpause_busy", 32'(busy), 1);
        chk("evpause_ce", 32'(count_enable), 0);
        chk("evpause_rl", 32'(reps_left), 1);
        e0 = cyc;
        for (int i = 0; i < 40 && done !== 1'b1; i++) step();
        chk("evpause_done", 32'(done), 1);
        chk("evpause_len", 32'(cyc - e0), 3);
        step();

        // Asynchronous reset in the middle of a run, P=5 R=3
        period = 4'd5;
        reps   = 8'd3;
        start  = 1'b1;
        step();
        start = 1'b0;
        repeat (7) step();
        chk("mid_rl2", 32'(reps_left), 2);
        #2;
        nrst = 1'b0;
        #1;
        chk("arst_clear", 32'(clear), 1);
        chk("arst_ce", 32'(count_enable), 0);
        chk("arst_busy", 32'(busy), 0);
        chk("arst_done", 32'(done), 0);
        chk("arst_rv", 32'(rollover_val), 0);
        chk("arst_rl", 32'(reps_left), 0);
        step();
        step();
        chk("arst_hold_busy", 32'(busy), 0);
        chk("arst_hold_clear", 32'(clear), 1);
        nrst = 1'b1;
        step();
        step();
        chk("arst_rel_busy", 32'(busy), 0);
        chk("arst_rel_clear", 32'(clear), 1);
        chk("arst_rel_rl", 32'(reps_left), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
